// File: rtl/chip8_draw_engine.sv
// chip8_draw_engine
//
// DXYN sprite draw unit. It takes a latched request (Vx, Vy, N, I). For each
// sprite row it fetches one byte from program RAM and the matching 64-bit
// framebuffer row. It XORs the shifted sprite byte into that row and writes
// the row back. Any pixel turned off by the XOR sets the collision flag.
//
// Ports
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   start      : draw request, accepted only while busy=0
//   vx, vy     : sprite X/Y coordinates (wrapped to 64x32 at the start)
//   n          : sprite height in rows (0 = nothing drawn)
//   i_addr     : sprite base address (low RAM_AW bits used)
//   busy       : high while the engine is not idle
//   done       : one-cycle completion pulse
//   collision  : VF result, valid from done until the next accepted start
//   ram_addr   : sprite byte address, registered
//   ram_rdata  : RAM read data, one cycle after ram_addr
//   fb_addr    : framebuffer row address, registered
//   fb_rdata   : framebuffer row read data, one cycle after fb_addr
//   fb_wdata   : framebuffer row write data
//   fb_we      : framebuffer row write strobe
//
// Framebuffer layout: column c of a row is bit 63-c, so the MSB is the
// leftmost pixel.

module chip8_draw_engine #(
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        vx,
  input  logic [7:0]        vy,
  input  logic [3:0]        n,
  input  logic [15:0]       i_addr,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic [4:0]        fb_addr,
  input  logic [63:0]       fb_rdata,
  output logic [63:0]       fb_wdata,
  output logic              fb_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_XOR,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [5:0]        r_x0;
  logic [4:0]        r_y0;
  logic [3:0]        r_n;
  logic [RAM_AW-1:0] r_base;
  logic [3:0]        r_row;
  logic              r_acc;

  logic [63:0]       w_mask;
  logic [4:0]        w_row_next;
  logic [5:0]        w_y_next;
  logic              w_more;
  logic              w_unused;

  // Place sprite bit 7-k at column x0+k. The column sum is 7 bits wide so
  // that positions past 63 can be detected and dropped instead of wrapped.
  function automatic logic [63:0] build_mask(input logic [7:0] spr,
                                             input logic [5:0] x0);
    logic [63:0] m;
    logic [6:0]  col;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      col = {1'b0, x0} + 7'(k);
      if (col < 7'd64) m[6'(7'd63 - col)] = spr[7-k];
    end
    return m;
  endfunction

  assign w_mask     = build_mask(ram_rdata, r_x0);
  assign w_row_next = {1'b0, r_row} + 5'd1;
  // Row index is 6 bits wide so that rows past 31 are clipped, not wrapped.
  assign w_y_next   = {1'b0, r_y0} + {1'b0, w_row_next};
  assign w_more     = (w_row_next < {1'b0, r_n}) && (w_y_next <= 6'd31);

  // The start coordinates wrap, so the high coordinate bits are never needed.
  assign w_unused   = ^{vx[7:6], vy[7:5], i_addr[15:RAM_AW]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_acc     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      fb_we     <= 1'b0;
      ram_addr  <= '0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
    end else begin
      case (r_state)
        // Idle: latch the request and present row 0 addresses for FETCH.
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_x0      <= vx[5:0];
            r_y0      <= vy[4:0];
            r_n       <= n;
            r_base    <= i_addr[RAM_AW-1:0];
            r_row     <= '0;
            r_acc     <= 1'b0;
            collision <= 1'b0;
            busy      <= 1'b1;
            ram_addr  <= i_addr[RAM_AW-1:0];
            fb_addr   <= vy[4:0];
            if (n != 4'd0) begin
              r_state <= S_FETCH;
            end else begin
              // Nothing to draw: finish on the next cycle.
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
        end

        // Fetch: both memories are reading the registered addresses.
        S_FETCH: begin
          r_state <= S_XOR;
        end

        // XOR: read data is valid; build the new row and arm the write.
        S_XOR: begin
          fb_wdata <= fb_rdata ^ w_mask;
          if ((fb_rdata & w_mask) != 64'd0) r_acc <= 1'b1;
          fb_we    <= 1'b1;
          r_state  <= S_WRITE;
        end

        // Write: row is on the bus this cycle; advance or finish.
        S_WRITE: begin
          fb_we <= 1'b0;
          r_row <= w_row_next[3:0];
          if (w_more) begin
            ram_addr <= r_base + RAM_AW'(w_row_next);
            fb_addr  <= w_y_next[4:0];
            r_state  <= S_FETCH;
          end else begin
            done      <= 1'b1;
            collision <= r_acc;
            r_state   <= S_DONE;
          end
        end

        // Done: the pulse is visible this cycle; start is still ignored.
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          fb_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
